// File: rtl/async_fifo_dc_sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high reset to zero
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/async_fifo_dc.sv
// async_fifo_dc: dual-clock FIFO with gray-coded pointer crossing and conservative flags
module async_fifo_dc #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  wt_clk,
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  wt_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  underflow
);
  localparam int MASK_I = 3 << (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH:0] FULL_MASK = MASK_I[PTR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0] wr_bin, wr_gray, wr_bin_next, wr_gray_next, rd_sync;
  logic [PTR_WIDTH:0] rd_bin, rd_gray, rd_bin_next, rd_gray_next, wr_sync;
  logic wr_inc, rd_inc;
  sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_rd2wt (.clk(wt_clk), .rst(rst), .d(rd_gray), .q(rd_sync));
  sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_wt2rd (.clk(rd_clk), .rst(rst), .d(wr_gray), .q(wr_sync));
  always_comb begin
    wr_inc       = wt_en & ~full;
    wr_bin_next  = wr_bin + {{PTR_WIDTH{1'b0}}, wr_inc};
    wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    rd_inc       = rd_en & ~empty;
    rd_bin_next  = rd_bin + {{PTR_WIDTH{1'b0}}, rd_inc};
    rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
  end
  always_ff @(posedge wt_clk)
    if (wr_inc) mem[wr_bin[PTR_WIDTH-1:0]] <= wdata;
  // full compares against the read pointer with its top two gray bits inverted
  always_ff @(posedge wt_clk or posedge rst)
    if (rst) begin
      wr_bin   <= '0;
      wr_gray  <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_bin   <= wr_bin_next;
      wr_gray  <= wr_gray_next;
      full     <= wr_gray_next == (rd_sync ^ FULL_MASK);
      overflow <= wt_en & full;
    end
  always_ff @(posedge rd_clk or posedge rst)
    if (rst) begin
      rd_bin    <= '0;
      rd_gray   <= '0;
      empty     <= 1'b1;
      underflow <= 1'b0;
      rdata     <= '0;
    end else begin
      rd_bin    <= rd_bin_next;
      rd_gray   <= rd_gray_next;
      empty     <= rd_gray_next == wr_sync;
      underflow <= rd_en & empty;
      if (rd_inc) rdata <= mem[rd_bin[PTR_WIDTH-1:0]];
    end
endmodule

// File: tb/tb_async_fifo_dc.sv
// tb_async_fifo_dc: randomized scoreboard bench for the dual-clock FIFO
module tb_async_fifo_dc;
  localparam int DEPTH = 16;
  logic wt_clk = 0, rd_clk = 0, rst = 1, wt_en = 0, rd_en = 0;
  logic [7:0] wdata = 0, rdata;
  logic full, overflow, empty, underflow;
  logic [7:0] sb[$];
  logic [7:0] exp_rd, last_rd = 0;
  logic ovf_exp = 0, unf_exp = 0, rd_acc = 0;
  int checks = 0, failures = 0;
  int acc_w = 0, acc_r = 0, rej_w = 0, ovf_seen = 0, unf_seen = 0;

  async_fifo_dc #(.DATA_WIDTH(8), .DEPTH(DEPTH), .PTR_WIDTH(4)) dut (
    .wt_clk(wt_clk), .rd_clk(rd_clk), .rst(rst), .wt_en(wt_en), .wdata(wdata),
    .full(full), .overflow(overflow), .rd_en(rd_en), .rdata(rdata),
    .empty(empty), .underflow(underflow)
  );

  // write edges land on even times, read edges on odd times, so they never coincide
  always #2 wt_clk = ~wt_clk;
  initial begin
    #1;
    forever #4 rd_clk = ~rd_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge wt_clk) if (!rst) begin
    if (wt_en && !full) begin
      sb.push_back(wdata);
      acc_w++;
    end
    ovf_exp = wt_en && full;
    if (ovf_exp) rej_w++;
  end

  always @(negedge wt_clk) if (!rst) begin
    check("overflow", overflow, ovf_exp);
    if (overflow) ovf_seen++;
    if (!full) check("full_safe", sb.size() < DEPTH, 1);
  end

  always @(posedge rd_clk) if (!rst) begin
    rd_acc  = rd_en && !empty;
    unf_exp = rd_en && empty;
    if (rd_acc) begin
      acc_r++;
      if (sb.size() == 0) begin
        exp_rd = 'x;
        check("sb_underrun", 1, 0);
      end else exp_rd = sb.pop_front();
    end
  end

  always @(negedge rd_clk) if (!rst) begin
    check("underflow", underflow, unf_exp);
    if (underflow) unf_seen++;
    if (rd_acc) begin
      check("rdata", rdata, exp_rd);
      last_rd = exp_rd;
    end else check("rdata_hold", rdata, last_rd);
    if (!empty) check("empty_safe", sb.size() > 0, 1);
  end

  task automatic do_reset();
    @(posedge rd_clk);
    #2;
    rst = 1; wt_en = 0; rd_en = 0;
    sb.delete();
    ovf_exp = 0; unf_exp = 0; rd_acc = 0; last_rd = 0;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rdata", rdata, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    #11;
    acc_w = 0; acc_r = 0; rej_w = 0; ovf_seen = 0; unf_seen = 0;
    rst = 0;
  endtask

  task automatic write_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge wt_clk);
      wt_en = 1;
      wdata = 8'($urandom_range(1, 255));
    end
    @(negedge wt_clk);
    wt_en = 0;
  endtask

  task automatic read_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rd_clk);
      rd_en = 1;
    end
    @(negedge rd_clk);
    rd_en = 0;
  endtask

  initial begin
    int guard;
    do_reset();
    write_burst(16);
    repeat (2) @(negedge wt_clk);
    check("full_after_16", full, 1);
    repeat (3) @(negedge rd_clk);
    check("empty_fell", empty, 0);
    check("no_overflow_16", ovf_seen, 0);

    read_burst(16);
    repeat (2) @(negedge rd_clk);
    check("empty_after_16", empty, 1);
    check("reads_16", acc_r, 16);
    check("no_underflow_16", unf_seen, 0);

    do_reset();
    write_burst(17);
    repeat (2) @(negedge wt_clk);
    check("ovf_pulses", ovf_seen, 1);
    check("accepted_17", acc_w, 16);
    repeat (4) @(negedge rd_clk);
    read_burst(16);
    repeat (2) @(negedge rd_clk);
    check("ovf_drained", sb.size(), 0);
    check("ovf_empty", empty, 1);

    do_reset();
    write_burst(16);
    repeat (4) @(negedge rd_clk);
    read_burst(17);
    repeat (2) @(negedge rd_clk);
    check("unf_pulses", unf_seen, 1);
    check("unf_reads", acc_r, 16);

    do_reset();
    fork
      for (int i = 0; i < 50; i++) begin
        repeat ($urandom_range(1, 5)) @(negedge wt_clk);
        wt_en = 1;
        wdata = 8'($urandom_range(1, 255));
        @(negedge wt_clk);
        wt_en = 0;
      end
      for (int i = 0; i < 50; i++) begin
        repeat ($urandom_range(1, 5)) @(negedge rd_clk);
        rd_en = 1;
        @(negedge rd_clk);
        rd_en = 0;
      end
    join
    repeat (4) @(negedge rd_clk);
    check("ovf_vs_rejected", ovf_seen, rej_w);
    check("conc_empty", empty, acc_w == acc_r);
    guard = 0;
    while (acc_r < acc_w && guard < 200) begin
      @(negedge rd_clk);
      rd_en = !empty;
      guard++;
    end
    rd_en = 0;
    check("drain_timeout", guard < 200, 1);
    repeat (3) @(negedge rd_clk);
    check("conc_final_empty", empty, 1);
    check("conc_sb_empty", sb.size(), 0);

    do_reset();
    write_burst(6);
    repeat (4) @(negedge rd_clk);
    read_burst(1);
    repeat (2) @(negedge rd_clk);
    check("queued_5", sb.size(), 5);
    do_reset();
    write_burst(1);
    repeat (4) @(negedge rd_clk);
    read_burst(1);
    repeat (2) @(negedge rd_clk);
    check("post_rst_reads", acc_r, 1);
    check("post_rst_sb", sb.size(), 0);
    check("post_rst_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
